// File: rtl/uart_rx_word.sv
// -----------------------------------------------------------------------------
// uart_rx_word
//
// 8N1 UART receiver that assembles received bytes into command words for the
// logIP command decoder. The first byte of a word lands in the MSB. If
// SHORT_CMD is 1, a first byte with bit 7 clear completes the word on its own.
// A stop bit sampled low reports a framing error and drops the partial word.
//
// Optional feature (macro LOGIP_UART_RX_TIMEOUT_EN):
//   When the macro is defined, a partial word that sees no new start bit for
//   TIMEOUT_BITS*CLK_PER_BIT cycles is dropped and timeout_o pulses. When the
//   macro is undefined, timeout_o is tied to 0 and a partial word waits
//   indefinitely.
//
// Parameters:
//   CLK_PER_BIT  clock cycles per UART bit (>= 4)
//   WORD_BYTES   bytes per long word (>= 1)
//   SYNC_STAGES  synchroniser flops on rx_async_i (>= 2)
//   SHORT_CMD    1: first byte with bit 7 = 0 is a complete word
//   TIMEOUT_BITS inter-byte timeout in bit times (used only with the macro)
//
// Ports:
//   clk_i        system clock
//   rst_in       asynchronous active-low reset
//   rx_async_i   serial line, idle high, asynchronous to clk_i
//   data_o       last assembled word, valid while stb_o is high, held otherwise
//   stb_o        one-cycle strobe when a word completes
//   frame_err_o  one-cycle pulse when a stop bit is sampled low
//   timeout_o    one-cycle pulse when a partial word is dropped by the timeout
//   dbg_state_o  current receiver FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Output handshake: there is no ready signal. A word is presented on data_o
// during the single cycle stb_o is high; the consumer must take it then. The
// value stays on data_o until the next strobe overwrites it. stb_o,
// frame_err_o and timeout_o never assert in the same cycle.
// -----------------------------------------------------------------------------
module uart_rx_word #(
  parameter int CLK_PER_BIT  = 16,
  parameter int WORD_BYTES   = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int SHORT_CMD    = 1,
  parameter int TIMEOUT_BITS = 100
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic                    rx_async_i,
  output logic [8*WORD_BYTES-1:0] data_o,
  output logic                    stb_o,
  output logic                    frame_err_o,
  output logic                    timeout_o,
  output logic [1:0]              dbg_state_o
);

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(WORD_BYTES + 1);
  localparam int DW = 8 * WORD_BYTES;

  // Baud counter compare points. The counter is cleared on the cycle a state
  // is entered, so a match on N-1 lands exactly N cycles after the previous
  // sample point (or after t0 for the start check).
  localparam logic [BW-1:0] HALF_M1  = BW'(CLK_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_M1  = BW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

  if (CLK_PER_BIT < 4 || WORD_BYTES < 1 || SYNC_STAGES < 2 ||
      TIMEOUT_BITS < 1 || (SHORT_CMD != 0 && SHORT_CMD != 1)) begin : g_bad_params
    $error("uart_rx_word: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser; reset to the idle (high) line level so that reset
  // release never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_async_i};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_t          r_state,  w_state_nxt;
  logic [BW-1:0]   r_baud,   w_baud_nxt;
  logic [2:0]      r_bit,    w_bit_nxt;
  logic [IW-1:0]   r_idx,    w_idx_nxt;
  logic [7:0]      r_shift,  w_shift_nxt;
  logic [DW-1:0]   r_word,   w_word_nxt;
  logic [DW-1:0]   r_data,   w_data_nxt;
  logic            r_stb,    w_stb_nxt;
  logic            r_ferr,   w_ferr_nxt;
  logic [DW-1:0]   w_ins;
  logic            w_last;
  logic            w_short;
  logic            w_to_fire;

  // Partial word with the byte just shifted in placed at its slot. r_word is
  // zero whenever r_idx is zero, so unreceived bytes of a short word read 0.
  always_comb begin
    w_ins = r_word;
    for (int j = 0; j < WORD_BYTES; j++) begin
      if (r_idx == IW'(j)) begin
        w_ins[8*(WORD_BYTES-j)-1 -: 8] = r_shift;
      end
    end
  end

  assign w_last  = (r_idx == LAST_IDX);
  assign w_short = (SHORT_CMD == 1) && (r_idx == '0) && !r_shift[7];

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_word_nxt  = r_word;
    w_data_nxt  = r_data;
    w_stb_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
        end else if (w_to_fire) begin
          w_idx_nxt  = '0;
          w_word_nxt = '0;
        end
      end

      S_START: begin
        if (r_baud == HALF_M1) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          // A line that is high again at mid-start is treated as a glitch.
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      S_DATA: begin
        if (r_baud == FULL_M1) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};  // LSB arrives first
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      S_STOP: begin
        if (r_baud == FULL_M1) begin
          // Return to IDLE right after the sample so a back-to-back start bit
          // is seen without waiting for the end of the stop bit.
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
          if (w_rx_s) begin
            if (w_last || w_short) begin
              w_data_nxt = w_ins;
              w_stb_nxt  = 1'b1;
              w_idx_nxt  = '0;
              w_word_nxt = '0;
            end else begin
              w_word_nxt = w_ins;
              w_idx_nxt  = r_idx + 1'b1;
            end
          end else begin
            w_ferr_nxt = 1'b1;
            w_idx_nxt  = '0;
            w_word_nxt = '0;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_data  <= '0;
      r_stb   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_word  <= w_word_nxt;
      r_data  <= w_data_nxt;
      r_stb   <= w_stb_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef LOGIP_UART_RX_TIMEOUT_EN
  localparam int            TO_CYC = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int            TW     = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_M1  = TW'(TO_CYC - 1);

  logic [TW-1:0] r_tocnt;
  logic          r_to;
  logic          w_to_run;

  // Counts idle cycles while a partial word is pending; a start bit (line low
  // in IDLE) restarts it and takes priority over an expiry in the same cycle.
  assign w_to_run  = (r_state == S_IDLE) && (r_idx != '0) && w_rx_s;
  assign w_to_fire = w_to_run && (r_tocnt == TO_M1);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_tocnt <= '0;
      r_to    <= 1'b0;
    end else begin
      r_to <= w_to_fire;
      if (!w_to_run || w_to_fire) begin
        r_tocnt <= '0;
      end else begin
        r_tocnt <= r_tocnt + 1'b1;
      end
    end
  end

  assign timeout_o = r_to;
`else
  assign w_to_fire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign data_o      = r_data;
  assign stb_o       = r_stb;
  assign frame_err_o = r_ferr;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_rx_word.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_word
//
// Directed bench for uart_rx_word with CLK_PER_BIT=16, WORD_BYTES=5.
// Expected words are queued when the last byte of a word is driven and popped
// by the monitor when stb_o fires. Pulse counters track stb_o, frame_err_o and
// timeout_o so each step can check how many of each it caused.
// -----------------------------------------------------------------------------
module tb_uart_rx_word;

  localparam int CPB = 16;
  localparam int WB  = 5;
  localparam int W   = 8 * WB;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk_i = 1'b0;
  logic         rst_in = 1'b0;
  logic         rx = 1'b1;
  logic [W-1:0] data_o;
  logic         stb_o;
  logic         frame_err_o;
  logic         timeout_o;
  logic [1:0]   dbg_state_o;

  always #5 clk_i = ~clk_i;

  uart_rx_word #(
    .CLK_PER_BIT (CPB),
    .WORD_BYTES  (WB),
    .SYNC_STAGES (2),
    .SHORT_CMD   (1),
    .TIMEOUT_BITS(100)
  ) dut (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .rx_async_i (rx),
    .data_o     (data_o),
    .stb_o      (stb_o),
    .frame_err_o(frame_err_o),
    .timeout_o  (timeout_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int ferr_cnt = 0;
  int to_cnt = 0;
  int last_stb_cyc = 0;
  int last_send_cyc = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk_i) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk_i) begin
    if (rst_in) begin
      if (stb_o || frame_err_o || timeout_o) begin
        check("outputs_exclusive", 64'(stb_o) + 64'(frame_err_o) + 64'(timeout_o), 64'd1);
      end
      if (stb_o) begin
        stb_cnt++;
        last_stb_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("stb_expected", 64'd0, 64'd1);
        end else begin
          check("word", 64'(data_o), 64'(exp_q.pop_front()));
        end
      end
      if (frame_err_o) ferr_cnt++;
      if (timeout_o) to_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    last_send_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx = stop_val;
    repeat (CPB) @(negedge clk_i);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int k = 0; k < WB; k++) begin
      send_byte(w[W-1-8*k -: 8], 1'b1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int s_stb, s_ferr, s_to, short_start;
    logic [W-1:0] w;

    // Reset
    rst_in = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk_i);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_stb", 64'(stb_o), 64'd0);
    check("rst_ferr", 64'(frame_err_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'd0);

    // Short command
    s_stb = stb_cnt;
    exp_q.push_back(40'h01_0000_0000);
    send_byte(8'h01, 1'b1);
    short_start = last_send_cyc;
    idle(20);
    check("short_stb_count", 64'(stb_cnt - s_stb), 64'd1);
    check("short_latency", 64'(last_stb_cyc - short_start), 64'd155);
    check("short_hold", 64'(data_o), 64'h01_0000_0000);

    // Long command, back-to-back bytes
    s_stb = stb_cnt;
    w = 40'h80_1234_5678;
    exp_q.push_back(w);
    send_word(w);
    idle(20);
    check("long_stb_count", 64'(stb_cnt - s_stb), 64'd1);
    check("long_hold", 64'(data_o), 64'(w));

    // Framing error then a good word
    s_stb = stb_cnt;
    s_ferr = ferr_cnt;
    send_byte(8'h80, 1'b0);
    idle(40);
    check("ferr_count", 64'(ferr_cnt - s_ferr), 64'd1);
    check("ferr_no_stb", 64'(stb_cnt - s_stb), 64'd0);
    check("ferr_data_held", 64'(data_o), 64'(w));
    w = 40'hC0_AABB_CCDD;
    exp_q.push_back(w);
    send_word(w);
    idle(20);
    check("after_ferr_stb_count", 64'(stb_cnt - s_stb), 64'd1);
    check("after_ferr_data", 64'(data_o), 64'(w));

    // Glitch on the line
    s_stb = stb_cnt;
    s_ferr = ferr_cnt;
    s_to = to_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk_i);
    idle(30);
    check("glitch_state", 64'(dbg_state_o), 64'd0);
    check("glitch_outputs", 64'((stb_cnt - s_stb) + (ferr_cnt - s_ferr) + (to_cnt - s_to)), 64'd0);
    exp_q.push_back(40'h05_0000_0000);
    send_byte(8'h05, 1'b1);
    idle(20);
    check("glitch_next_stb", 64'(stb_cnt - s_stb), 64'd1);

    // Inter-byte timeout
    s_stb = stb_cnt;
    s_to = to_cnt;
    send_byte(8'h80, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(1600);
`ifdef LOGIP_UART_RX_TIMEOUT_EN
    check("timeout_count", 64'(to_cnt - s_to), 64'd1);
    check("timeout_no_stb", 64'(stb_cnt - s_stb), 64'd0);
    w = 40'h81_0102_0304;
    exp_q.push_back(w);
    send_word(w);
`else
    check("timeout_count", 64'(to_cnt - s_to), 64'd0);
    check("timeout_no_stb", 64'(stb_cnt - s_stb), 64'd0);
    exp_q.push_back(40'h80_1181_0102);
    send_byte(8'h81, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
`endif
    idle(20);
    check("timeout_stb_count", 64'(stb_cnt - s_stb), 64'd1);

    // Reset in the middle of the third byte of a word
    send_byte(8'h80, 1'b1);
    send_byte(8'h22, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h33 >> i) & 8'h01;
      repeat (CPB) @(negedge clk_i);
    end
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk_i);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_i);
    check("midrst_data", 64'(data_o), 64'd0);
    check("midrst_flags", 64'({stb_o, frame_err_o, timeout_o}), 64'd0);
    check("midrst_state", 64'(dbg_state_o), 64'd0);
    rst_in = 1'b1;
    idle(40);
    check("midrst_data_after", 64'(data_o), 64'd0);
    s_stb = stb_cnt;
    w = 40'h83_0A0B_0C0D;
    exp_q.push_back(w);
    send_word(w);
    idle(20);
    check("midrst_stb_count", 64'(stb_cnt - s_stb), 64'd1);
    check("midrst_data_final", 64'(data_o), 64'(w));

    // Everything queued must have been consumed
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
